// File: rtl/vblank_scheduler.sv
// vblank_scheduler: opens one update window per frame over vertical blanking
// and grants the game-state registers to one requester at a time, rotating
// first priority every frame.
// Optional watchdog: define VBLANK_SCHED_WATCHDOG_EN to abandon a grant that
// sees no done within TIMEOUT cycles.
module vblank_scheduler #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned VD      = 480,
    parameter int unsigned HMAX    = 799,
    parameter int unsigned VMAX    = 524,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             p_tick,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             clr_overrun,
    output logic [N_REQ-1:0] grant,
    output logic             frame_tick,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      frame_count
);

    localparam int unsigned IW = $clog2(N_REQ);

    localparam logic [9:0] OPEN_X  = '0;
    localparam logic [9:0] OPEN_Y  = 10'(VD);
    localparam logic [9:0] CLOSE_X = 10'(HMAX);
    localparam logic [9:0] CLOSE_Y = 10'(VMAX);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     start_q, start_d;
    logic              frame_tick_q, frame_tick_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              open_w;
    logic              close_w;
    logic              done_hit;
    logic              wd_expire;
    logic [N_REQ-1:0]  pend_after;
    logic [N_REQ-1:0]  eff;
    logic [N_REQ-1:0]  pick;
    logic [2*N_REQ-1:0] rot2;
    logic [N_REQ-1:0]  rot;
    logic [N_REQ-1:0]  rot_oh;
    logic [2*N_REQ-1:0] pick2;

`ifdef VBLANK_SCHED_WATCHDOG_EN
    localparam int unsigned WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] wd_q, wd_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    assign grant       = grant_q;
    assign frame_tick  = frame_tick_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

    // State register and all datapath flops; reset drops grant immediately
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            pending_q     <= '0;
            rr_q          <= '0;
            start_q       <= '0;
            frame_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef VBLANK_SCHED_WATCHDOG_EN
            wd_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            pending_q     <= pending_d;
            rr_q          <= rr_d;
            start_q       <= start_d;
            frame_tick_q  <= frame_tick_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
`ifdef VBLANK_SCHED_WATCHDOG_EN
            wd_q          <= wd_d;
`endif
        end
    end

    // Window events, effective request set and rotating-priority pick
    always_comb begin
        open_w     = p_tick && (x == OPEN_X) && (y == OPEN_Y);
        close_w    = p_tick && (x == CLOSE_X) && (y == CLOSE_Y);
        done_hit   = (state_q == GRANT) && ((done & grant_q) != '0);
        // A done in the CLOSE cycle retires its bit before the overrun check
        pend_after = done_hit ? (pending_q & ~grant_q) : pending_q;
        eff        = pend_after & req;
`ifdef VBLANK_SCHED_WATCHDOG_EN
        wd_expire  = (state_q == GRANT) && (wd_q == WDW'(TIMEOUT - 1));
`else
        wd_expire  = 1'b0;
`endif
        // Rotate so start_q lands at bit 0, isolate lowest set bit, rotate back
        rot2   = {eff, eff} >> start_q;
        rot    = rot2[N_REQ-1:0];
        rot_oh = rot & (~rot + N_REQ'(1));
        pick2  = {rot_oh, rot_oh} << start_q;
        pick   = pick2[2*N_REQ-1:N_REQ];
    end

    // Next-state logic: CLOSE beats done, done beats watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (open_w) state_d = SELECT;
            SELECT: begin
                if (close_w || (eff == '0)) state_d = IDLE;
                else                        state_d = GRANT;
            end
            GRANT: begin
                if (close_w)                    state_d = IDLE;
                else if (done_hit || wd_expire) state_d = SELECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered-output and datapath next values
    always_comb begin
        grant_d       = grant_q;
        pending_d     = pending_q;
        rr_d          = rr_q;
        start_d       = start_q;
        frame_tick_d  = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = clr_overrun ? 1'b0 : overrun_q;
`ifdef VBLANK_SCHED_WATCHDOG_EN
        wd_d          = wd_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (open_w) begin
                    pending_d     = req;
                    // This frame scans from the old pointer; the next one from rr_d
                    start_d       = rr_q;
                    rr_d          = (rr_q == IW'(N_REQ - 1)) ? '0 : rr_q + IW'(1);
                    frame_tick_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            SELECT: begin
                if (close_w) begin
                    grant_d = '0;
                    if (eff != '0) overrun_d = 1'b1;
                end else begin
                    grant_d = pick;
`ifdef VBLANK_SCHED_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            GRANT: begin
                pending_d = pend_after;
                if (close_w) begin
                    grant_d = '0;
                    if (eff != '0) overrun_d = 1'b1;
                end else if (done_hit) begin
                    grant_d = '0;
                end else if (wd_expire) begin
                    pending_d = pending_q & ~grant_q;
                    grant_d   = '0;
                end else begin
`ifdef VBLANK_SCHED_WATCHDOG_EN
                    wd_d = wd_q + WDW'(1);
`endif
                end
            end
            default: grant_d = '0;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: round-robin order, withdrawn request,
// overrun/clear (or watchdog when VBLANK_SCHED_WATCHDOG_EN is defined),
// done coincident with CLOSE, and asynchronous reset mid-grant.
module tb_vblank_scheduler;

    localparam int unsigned N_REQ = 3;
    localparam int unsigned VD    = 480;
    localparam int unsigned HMAX  = 799;
    localparam int unsigned VMAX  = 524;

    logic             clk_100MHz = 1'b0;
    logic             reset;
    logic             p_tick;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             clr_overrun;
    logic [N_REQ-1:0] grant;
    logic             frame_tick;
    logic             busy;
    logic             overrun;
    logic [15:0]      frame_count;

    int n_cmp = 0;
    int n_err = 0;

    vblank_scheduler #(
        .N_REQ  (N_REQ),
        .VD     (VD),
        .HMAX   (HMAX),
        .VMAX   (VMAX),
        .TIMEOUT(16)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .p_tick     (p_tick),
        .x          (x),
        .y          (y),
        .req        (req),
        .done       (done),
        .clr_overrun(clr_overrun),
        .grant      (grant),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic neutral_xy();
        x = 10'd1;
        y = 10'd0;
    endtask

    // OPEN sampled at the next edge; returns at the frame_tick sample point
    task automatic open_frame();
        x = 10'd0;
        y = 10'(VD);
        tick();
        neutral_xy();
    endtask

    // Serve one grant: expect oh granted next cycle, done 5 cycles after grant
    task automatic serve(input string tag, input logic [N_REQ-1:0] oh);
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(oh));
        repeat (4) tick();
        check({tag, "_hold"}, 32'(grant), 32'(oh));
        done = oh;
        tick();
        done = '0;
        check({tag, "_drop"}, 32'(grant), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        p_tick = 1'b1;
        req = '0;
        done = '0;
        clr_overrun = 1'b0;
        neutral_xy();
        repeat (2) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ftick", 32'(frame_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_fcnt", 32'(frame_count), 32'd0);
        reset = 1'b0;
        tick();

        // OPEN position without p_tick must not open a window
        p_tick = 1'b0;
        x = 10'd0;
        y = 10'(VD);
        tick();
        p_tick = 1'b1;
        neutral_xy();
        check("noptick_ftick", 32'(frame_tick), 32'd0);
        check("noptick_busy", 32'(busy), 32'd0);

        // Frame 0: order 0,1,2
        req = 3'b111;
        open_frame();
        check("f0_ftick", 32'(frame_tick), 32'd1);
        check("f0_busy", 32'(busy), 32'd1);
        check("f0_fcnt", 32'(frame_count), 32'd1);
        check("f0_grant0", 32'(grant), 32'd0);
        serve("f0_a", 3'b001);
        serve("f0_b", 3'b010);
        serve("f0_c", 3'b100);
        check("f0_busy_sel", 32'(busy), 32'd1);
        tick();
        check("f0_busy_end", 32'(busy), 32'd0);
        check("f0_ovr", 32'(overrun), 32'd0);

        // Frame 1: order 1,2,0
        open_frame();
        check("f1_fcnt", 32'(frame_count), 32'd2);
        serve("f1_a", 3'b010);
        check("f1_ftick_gone", 32'(frame_tick), 32'd0);
        serve("f1_b", 3'b100);
        serve("f1_c", 3'b001);
        tick();
        check("f1_busy_end", 32'(busy), 32'd0);
        check("f1_ovr", 32'(overrun), 32'd0);

        // Frame 2 (scan starts at 2): req 011, requester 1 withdraws
        req = 3'b011;
        open_frame();
        check("f2_fcnt", 32'(frame_count), 32'd3);
        tick();
        check("wd_first", 32'(grant), 32'b001);
        req = 3'b001;
        repeat (3) tick();
        done = 3'b001;
        tick();
        done = '0;
        check("wdraw_drop", 32'(grant), 32'd0);
        check("wdraw_busy1", 32'(busy), 32'd1);
        tick();
        check("wdraw_busy0", 32'(busy), 32'd0);
        check("wdraw_nogrant", 32'(grant), 32'd0);

`ifdef VBLANK_SCHED_WATCHDOG_EN
        // Frame 3 (scan starts at 0): requester 0 never completes
        req = 3'b011;
        open_frame();
        check("f3_fcnt", 32'(frame_count), 32'd4);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("wdog_hold", 32'(grant), 32'b001);
        end
        tick();
        check("wdog_drop", 32'(grant), 32'd0);
        tick();
        check("wdog_next", 32'(grant), 32'b010);
        check("wdog_ovr", 32'(overrun), 32'd0);
        done = 3'b010;
        tick();
        done = '0;
        tick();
        check("wdog_busy0", 32'(busy), 32'd0);
`else
        // Frame 3 (scan starts at 0): requester 2 never completes
        req = 3'b100;
        open_frame();
        check("f3_fcnt", 32'(frame_count), 32'd4);
        tick();
        check("ovr_grant", 32'(grant), 32'b100);
        repeat (5) tick();
        x = 10'(HMAX);
        y = 10'(VMAX);
        tick();
        neutral_xy();
        check("ovr_grant_drop", 32'(grant), 32'd0);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_busy0", 32'(busy), 32'd0);
        repeat (2) tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
`endif

        // Frame 4 (scan starts at 1): done coincides with CLOSE
        req = 3'b010;
        open_frame();
        check("f4_fcnt", 32'(frame_count), 32'd5);
        tick();
        check("dc_grant", 32'(grant), 32'b010);
        repeat (2) tick();
        done = 3'b010;
        x = 10'(HMAX);
        y = 10'(VMAX);
        tick();
        done = '0;
        neutral_xy();
        check("dc_grant_drop", 32'(grant), 32'd0);
        check("dc_ovr", 32'(overrun), 32'd0);
        check("dc_busy0", 32'(busy), 32'd0);
        tick();
        check("dc_idle", 32'(busy), 32'd0);

        // Frame 5 (scan starts at 2): reset mid-grant
        open_frame();
        check("f5_fcnt", 32'(frame_count), 32'd6);
        tick();
        check("rm_grant", 32'(grant), 32'b010);
        reset = 1'b1;
        #2;
        check("rm_async_grant", 32'(grant), 32'd0);
        check("rm_async_fcnt", 32'(frame_count), 32'd0);
        check("rm_async_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        req = 3'b111;
        open_frame();
        check("rm_fcnt", 32'(frame_count), 32'd1);
        tick();
        check("rm_first", 32'(grant), 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
